// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART receive path.
//   rx_state_e      : receiver FSM state encoding
//   UART_DATA_BITS  : default data bits per frame
//   UART_OVERSAMPLE : default bclk cycles per bit
//   uart_parity()   : expected parity bit for a data word
// Optional feature macro: UART_RX_PARITY_EN (the PARITY state is only
// reachable when the receiver is built with it).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // Expected parity bit: even parity when odd=0, odd parity when odd=1.
    // Narrower data words are zero-extended by the caller.
    function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                         input logic                      odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Brings the asynchronous rxd line into the bclk domain and keeps a one-cycle
// delayed copy so the FSM can detect a falling edge.
// Ports:
//   bclk    in  : 16x baud clock
//   resetb  in  : asynchronous reset, active-low
//   rxd     in  : raw serial line (idle high)
//   rx_s    out : rxd after SYNC_STAGES flops
//   rx_prev out : rx_s delayed by one bclk cycle
// All flops reset to 1 so that reset never looks like a start bit.
// -----------------------------------------------------------------------------
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic bclk,
    input  logic resetb,
    input  logic rxd,
    output logic rx_s,
    output logic rx_prev
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser chain and edge-detect history register.
    always_ff @(posedge bclk or negedge resetb) begin
        if (!resetb) begin
            sync_r <= '1;
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rxd};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rx_s    = sync_r[SYNC_STAGES-1];
    assign rx_prev = prev_r;

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// UART receive stage with 16x oversampling (8N1 by default). Finds the start
// bit, samples each bit at mid-bit, checks the stop bit and hands the byte to
// the consumer through a valid/ack handshake with sticky error flags.
// Ports:
//   bclk       in  : 16x baud clock, all state updates on posedge
//   resetb     in  : asynchronous reset, active-low
//   rxd        in  : serial line, idle high, asynchronous to bclk
//   rx_ack     in  : consumer acknowledge (clears valid and all flags)
//   rx_data    out : last good received byte
//   rx_valid   out : rx_data holds an unread byte
//   overrun    out : sticky, a byte completed while rx_valid was set
//   frame_err  out : sticky, stop bit sampled low
//   parity_err out : sticky, parity mismatch (0 unless parity is built in)
//   busy       out : registered, high whenever the next state is not IDLE
// Optional feature macro: UART_RX_PARITY_EN adds PARITY_ODD and a parity bit
// between the last data bit and the stop bit.
// -----------------------------------------------------------------------------
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD  = 1'b0
`endif
) (
    input  logic                 bclk,
    input  logic                 resetb,
    input  logic                 rxd,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 overrun,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;
    logic rx_prev;

    rx_state_e            state_r,   state_nxt_s;
    logic [CNT_W-1:0]     cnt_r,     cnt_nxt_s;
    logic [IDX_W-1:0]     idx_r,     idx_nxt_s;
    logic [DATA_BITS-1:0] shreg_r,   shreg_nxt_s;
    logic [DATA_BITS-1:0] rx_data_r, rx_data_nxt_s;
    logic                 valid_r,   valid_nxt_s;
    logic                 ovr_r,     ovr_nxt_s;
    logic                 ferr_r,    ferr_nxt_s;
    logic                 busy_r;

    // Flag values when no frame completes on this edge: ack clears them.
    logic valid_hold_s;
    logic ovr_hold_s;
    logic ferr_hold_s;

    assign valid_hold_s = valid_r & ~rx_ack;
    assign ovr_hold_s   = ovr_r   & ~rx_ack;
    assign ferr_hold_s  = ferr_r  & ~rx_ack;

`ifdef UART_RX_PARITY_EN
    logic par_bit_r, par_bit_nxt_s;
    logic perr_r,    perr_nxt_s;
    logic perr_hold_s;

    assign perr_hold_s = perr_r & ~rx_ack;
`endif

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .bclk    (bclk),
        .resetb  (resetb),
        .rxd     (rxd),
        .rx_s    (rx_s),
        .rx_prev (rx_prev)
    );

    // Next-state, datapath and output-flag logic.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        idx_nxt_s     = idx_r;
        shreg_nxt_s   = shreg_r;
        rx_data_nxt_s = rx_data_r;
        valid_nxt_s   = valid_hold_s;
        ovr_nxt_s     = ovr_hold_s;
        ferr_nxt_s    = ferr_hold_s;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt_s = par_bit_r;
        perr_nxt_s    = perr_hold_s;
`endif

        case (state_r)
            IDLE: begin
                // Only a high-to-low transition starts a frame, so a line
                // stuck low (break) never launches a false frame.
                if (!rx_s && rx_prev) begin
                    state_nxt_s = START;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end
            end

            START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_nxt_s = '0;
                    if (!rx_s) begin
                        state_nxt_s = DATA;
                        idx_nxt_s   = '0;
                    end else begin
                        // Glitch: abandon quietly, flags untouched.
                        state_nxt_s = IDLE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = '0;
                    shreg_nxt_s = {rx_s, shreg_r[DATA_BITS-1:1]};
                    if (idx_r == IDX_LAST) begin
                        idx_nxt_s = '0;
`ifdef UART_RX_PARITY_EN
                        state_nxt_s = PARITY;
`else
                        state_nxt_s = STOP;
`endif
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s     = '0;
                    par_bit_nxt_s = rx_s;
                    state_nxt_s   = STOP;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_nxt_s   = '0;
                    state_nxt_s = IDLE;
                    if (rx_s) begin
                        // An ack on this same edge frees the holding register.
                        if (!valid_r || rx_ack) begin
                            rx_data_nxt_s = shreg_r;
                            valid_nxt_s   = 1'b1;
                        end else begin
                            ovr_nxt_s = 1'b1;
                        end
                    end else begin
                        ferr_nxt_s = 1'b1;
                    end
`ifdef UART_RX_PARITY_EN
                    if (uart_parity(UART_DATA_BITS'(shreg_r), PARITY_ODD) != par_bit_r) begin
                        perr_nxt_s = 1'b1;
                    end else begin
                        perr_nxt_s = perr_hold_s;
                    end
`endif
                end else begin
                    cnt_nxt_s = cnt_r + CNT_W'(1);
                end
            end

            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
                idx_nxt_s   = '0;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge bclk or negedge resetb) begin
        if (!resetb) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            idx_r     <= '0;
            shreg_r   <= '0;
            rx_data_r <= '0;
            valid_r   <= 1'b0;
            ovr_r     <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            idx_r     <= idx_nxt_s;
            shreg_r   <= shreg_nxt_s;
            rx_data_r <= rx_data_nxt_s;
            valid_r   <= valid_nxt_s;
            ovr_r     <= ovr_nxt_s;
            ferr_r    <= ferr_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Captured parity bit and sticky parity error flag.
    always_ff @(posedge bclk or negedge resetb) begin
        if (!resetb) begin
            par_bit_r <= 1'b0;
            perr_r    <= 1'b0;
        end else begin
            par_bit_r <= par_bit_nxt_s;
            perr_r    <= perr_nxt_s;
        end
    end

    assign parity_err = perr_r;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_r;
    assign rx_valid  = valid_r;
    assign overrun   = ovr_r;
    assign frame_err = ferr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Self-checking bench for uart_receiver (default parameters). Frames are
// driven bit by bit on rxd; a frame-level model of the handshake and sticky
// flags supplies every expected value. Honours UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       bclk = 1'b0;
    logic       resetb;
    logic       rxd;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       overrun;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Frame-level reference model of the consumer-visible state.
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_overrun;
    logic       exp_ferr;
    logic       exp_perr;

    uart_receiver dut (
        .bclk       (bclk),
        .resetb     (resetb),
        .rxd        (rxd),
        .rx_ack     (rx_ack),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [12:0] dut_obs();
        return {rx_data, rx_valid, overrun, frame_err, parity_err, busy};
    endfunction

    function automatic logic [12:0] exp_obs(input logic exp_busy);
        return {exp_data, exp_valid, exp_overrun, exp_ferr, exp_perr, exp_busy};
    endfunction

    task automatic step();
        @(posedge bclk);
        #1;
    endtask

    task automatic model_reset();
        exp_data    = 8'h00;
        exp_valid   = 1'b0;
        exp_overrun = 1'b0;
        exp_ferr    = 1'b0;
        exp_perr    = 1'b0;
    endtask

    // One clock edge of the consumer-visible behaviour.
    task automatic model_edge(input bit ack, input bit done, input logic [7:0] d,
                              input bit stop, input bit par_bad);
        bit prev_valid;
        prev_valid = exp_valid;
        if (ack) begin
            exp_valid   = 1'b0;
            exp_overrun = 1'b0;
            exp_ferr    = 1'b0;
            exp_perr    = 1'b0;
        end
        if (done) begin
            if (stop) begin
                if (!prev_valid || ack) begin
                    exp_data  = d;
                    exp_valid = 1'b1;
                end else begin
                    exp_overrun = 1'b1;
                end
            end else begin
                exp_ferr = 1'b1;
            end
            if (par_bad) exp_perr = 1'b1;
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        step();
        rx_ack = 1'b0;
        model_edge(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Drive one complete frame. Returns the outputs one cycle before and
    // right after the stop-sample edge. rxd is left at the stop-bit level.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par,
                              input bit ack_on_stop,
                              output logic [12:0] obs_pre, output logic [12:0] obs_post);
        logic [15:0] fr;
        int nbits;
        int se;
        int s;
        bit par_bad;
        fr = 16'h0000;
        for (int i = 0; i < 8; i++) fr[1+i] = d[i];
        fr[9]  = PAR_EN ? par : stop;
        fr[10] = stop;
        nbits  = PAR_EN ? 11 : 10;
        // Start entry lands two edges after the fall (synchroniser), then
        // the stop sample is 8 + 16*(nbits-1) edges later.
        se      = 16 * (nbits - 1) + 10;
        par_bad = PAR_EN && (par != (^d));
        obs_pre  = 13'h0;
        obs_post = 13'h0;
        s = -1;
        for (int b = 0; b < nbits; b++) begin
            rxd = fr[b];
            for (int c = 0; c < 16; c++) begin
                if (s == se - 1) begin
                    obs_pre = dut_obs();
                    if (ack_on_stop) rx_ack = 1'b1;
                end
                step();
                s++;
                if (s == se) begin
                    rx_ack = 1'b0;
                    model_edge(ack_on_stop, 1'b1, d, stop, par_bad);
                    obs_post = dut_obs();
                end
            end
        end
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        rxd    = 1'b1;
        rx_ack = 1'b0;
        model_reset();
        repeat (3) step();
        checks++;
        if (dut_obs() !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL reset_hold: got %h expected %h", dut_obs(), exp_obs(1'b0));
        end
        resetb = 1'b1;
        repeat (5) step();
        checks++;
        if (dut_obs() !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL reset_release: got %h expected %h", dut_obs(), exp_obs(1'b0));
        end
    endtask

    task automatic test_basic_frame();
        logic [12:0] pre, post, exp_pre;
        exp_pre = exp_obs(1'b1);
        send_frame(8'hA5, 1'b1, ^(8'hA5), 1'b0, pre, post);
        checks++;
        if (pre !== exp_pre) begin
            failures++;
            $display("FAIL basic_pre_stop: got %h expected %h", pre, exp_pre);
        end
        checks++;
        if (post !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL basic_post_stop: got %h expected %h", post, exp_obs(1'b0));
        end
        checks++;
        if (post[12:4] !== {8'hA5, 1'b1}) begin
            failures++;
            $display("FAIL basic_data_valid: got %h expected %h", post[12:4], {8'hA5, 1'b1});
        end
        pulse_ack();
        checks++;
        if (dut_obs() !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL basic_ack_clear: got %h expected %h", dut_obs(), exp_obs(1'b0));
        end
    endtask

    task automatic test_glitch();
        int busy_cnt;
        busy_cnt = 0;
        rxd = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step();
            if (i == 3) rxd = 1'b1;
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 8) begin
            failures++;
            $display("FAIL glitch_busy_cycles: got %0d expected %0d", busy_cnt, 8);
        end
        checks++;
        if (dut_obs() !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL glitch_outputs: got %h expected %h", dut_obs(), exp_obs(1'b0));
        end
    endtask

    task automatic test_overrun();
        logic [12:0] pre, post;
        send_frame(8'h3C, 1'b1, ^(8'h3C), 1'b0, pre, post);
        repeat (5) step();
        send_frame(8'hC3, 1'b1, ^(8'hC3), 1'b0, pre, post);
        checks++;
        if (post !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL overrun_model: got %h expected %h", post, exp_obs(1'b0));
        end
        checks++;
        if ({post[12:4], post[3]} !== {8'h3C, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL overrun_keep: got %h expected %h", {post[12:4], post[3]}, {8'h3C, 1'b1, 1'b1});
        end
        pulse_ack();
        repeat (3) step();
        send_frame(8'h3C, 1'b1, ^(8'h3C), 1'b0, pre, post);
        repeat (5) step();
        send_frame(8'hC3, 1'b1, ^(8'hC3), 1'b1, pre, post);
        checks++;
        if ({post[12:4], post[3]} !== {8'hC3, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL ack_on_stop: got %h expected %h", {post[12:4], post[3]}, {8'hC3, 1'b1, 1'b0});
        end
        pulse_ack();
        repeat (3) step();
    endtask

    task automatic test_break();
        logic [12:0] pre, post;
        int busy_cnt;
        send_frame(8'h55, 1'b0, ^(8'h55), 1'b0, pre, post);
        checks++;
        if (post !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL break_frame_err: got %h expected %h", post, exp_obs(1'b0));
        end
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (busy) busy_cnt++;
        end
        checks++;
        if (busy_cnt !== 0) begin
            failures++;
            $display("FAIL break_no_start: got %0d busy cycles expected %0d", busy_cnt, 0);
        end
        checks++;
        if ({frame_err, rx_valid} !== 2'b10) begin
            failures++;
            $display("FAIL break_flags: got %b expected %b", {frame_err, rx_valid}, 2'b10);
        end
        rxd = 1'b1;
        repeat (10) step();
        send_frame(8'hE7, 1'b1, ^(8'hE7), 1'b0, pre, post);
        checks++;
        if (post !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL break_recover: got %h expected %h", post, exp_obs(1'b0));
        end
        pulse_ack();
        repeat (3) step();
    endtask

    task automatic test_reset_midframe();
        logic [12:0] pre, post;
        logic [7:0]  d;
        send_frame(8'h42, 1'b1, ^(8'h42), 1'b0, pre, post);
        repeat (4) step();
        d   = 8'h5A;
        rxd = 1'b0;
        repeat (16) step();
        for (int b = 0; b < 4; b++) begin
            rxd = d[b];
            repeat ((b == 3) ? 8 : 16) step();
        end
        resetb = 1'b0;
        #1;
        model_reset();
        checks++;
        if (dut_obs() !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL midframe_reset: got %h expected %h", dut_obs(), exp_obs(1'b0));
        end
        rxd = 1'b1;
        repeat (3) step();
        resetb = 1'b1;
        repeat (5) step();
        send_frame(8'h81, 1'b1, ^(8'h81), 1'b0, pre, post);
        checks++;
        if (post !== exp_obs(1'b0)) begin
            failures++;
            $display("FAIL after_reset_frame: got %h expected %h", post, exp_obs(1'b0));
        end
        pulse_ack();
        repeat (3) step();
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [12:0] pre, post;
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, pre, post);
        checks++;
        if ({post[12:4], post[1]} !== {8'h07, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL parity_bad: got %h expected %h", {post[12:4], post[1]}, {8'h07, 1'b1, 1'b1});
        end
        pulse_ack();
        repeat (3) step();
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, pre, post);
        checks++;
        if ({post[12:4], post[1]} !== {8'h07, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL parity_good: got %h expected %h", {post[12:4], post[1]}, {8'h07, 1'b1, 1'b0});
        end
        pulse_ack();
        repeat (3) step();
    endtask
`endif

    task automatic test_random();
        logic [12:0] pre, post, exp_pre;
        logic [7:0]  d;
        bit stop, par, ack_stop;
        for (int i = 0; i < 16; i++) begin
            d        = 8'($urandom);
            stop     = ($urandom_range(0, 4) != 0);
            ack_stop = ($urandom_range(0, 3) == 0);
            par      = (^d) ^ ($urandom_range(0, 3) == 0);
            exp_pre  = exp_obs(1'b1);
            send_frame(d, stop, par, ack_stop, pre, post);
            checks++;
            if (pre !== exp_pre) begin
                failures++;
                $display("FAIL random_pre[%0d]: got %h expected %h", i, pre, exp_pre);
            end
            checks++;
            if (post !== exp_obs(1'b0)) begin
                failures++;
                $display("FAIL random_post[%0d]: got %h expected %h", i, post, exp_obs(1'b0));
            end
            rxd = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                pulse_ack();
                checks++;
                if (dut_obs() !== exp_obs(1'b0)) begin
                    failures++;
                    $display("FAIL random_ack[%0d]: got %h expected %h", i, dut_obs(), exp_obs(1'b0));
                end
            end
            repeat ($urandom_range(3, 12)) step();
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
